cellrv32_cpu_cp_vector_queue: RTL and testbench

- Decoupling queue between the CPU vector dispatch and the vector register remapping stage.
- Buffers decoded to_vector instructions and presents the head on valid_o/instr_o; the remapper consumes the head by asserting pop_i.
- Enforces a reconfigure barrier: a head instruction with reconfigure=1 is withheld until the vector backend reports idle, so mappings are never reset under in-flight work.

---
 rtl/cellrv32_package.sv | 23 ++
 rtl/vq_fifo_mem.sv | 30 +++
 rtl/cellrv32_cpu_cp_vector_queue.sv | 128 ++++++++++++
 tb/tb_cellrv32_cpu_cp_vector_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cellrv32_package.sv
// Shared types for the CPU vector dispatch path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cellrv32_package;

    // Decoded instruction handed from CPU dispatch to the vector unit.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] dst;
        logic [4:0] src1;
        logic [4:0] src2;
        logic       vm;
        logic       reconfigure;  // vsetvl-class: resets the register mapping
    } to_vector;

    typedef enum logic [1:0] {
        VQ_RUN,
        VQ_DRAIN,
        VQ_RELEASE
    } vq_state_t;

endpackage

// File: rtl/vq_fifo_mem.sv
// Queue storage: DEPTH x to_vector register array, one write port, async read port.
// Latency: write visible on the read port the cycle after we; read is combinational.
// Backpressure: none; the owner decides when to write.
// Ports: clk_i, we/waddr/wdata (write port), raddr/rdata (read port).
// Contents are intentionally not reset; the owner gates rdata while empty.
module vq_fifo_mem
    import cellrv32_package::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  to_vector      wdata,
    input  logic [AW-1:0] raddr,
    output to_vector      rdata
);

    to_vector mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cellrv32_cpu_cp_vector_queue.sv
// Decoupling queue from vector dispatch to the remapper, with a reconfigure barrier.
// Latency: push in cycle N is presented at N+1 (0 cycles with CELLRV32_VQ_BYPASS_EN on an empty queue).
// Backpressure: ready_o drops when full (registered count); a reconfigure head waits for backend idle.
// Ports: clk_i/rstn_i; valid_i/instr_i/ready_o upstream push; valid_o/instr_o/pop_i head to remapper;
//        backend_idle_i barrier release; flush_i synchronous kill; count_o occupancy; is_idle_o empty+RUN.
// Optional macro: CELLRV32_VQ_BYPASS_EN enables combinational forwarding into an empty queue.
module cellrv32_cpu_cp_vector_queue
    import cellrv32_package::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    input  to_vector         instr_i,
    output logic             ready_o,
    output logic             valid_o,
    output to_vector         instr_o,
    input  logic             pop_i,
    input  logic             backend_idle_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             is_idle_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    vq_state_t        state_q, state_d;
    to_vector         head;
    logic             empty, full;
    logic             byp_vld, byp_take, wr_en, rd_adv;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    vq_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i (clk_i),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (instr_i),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // A bypassed instruction consumed in the same cycle never touches storage.
    assign byp_take = byp_vld && pop_i;
    assign wr_en    = valid_i && ready_o && !flush_i && !byp_take;
    // pop_i while nothing is presented is ignored.
    assign rd_adv   = pop_i && valid_o && !flush_i && !byp_take;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= VQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RELEASE does not recheck backend_idle_i: once the
    // backend has drained, nothing new can issue ahead of the reconfigure.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = VQ_RUN;
        end else begin
            unique case (state_q)
                VQ_RUN:     if (!empty && head.reconfigure) state_d = VQ_DRAIN;
                VQ_DRAIN:   if (backend_idle_i)             state_d = VQ_RELEASE;
                VQ_RELEASE: if (pop_i)                      state_d = VQ_RUN;
                default:                                    state_d = VQ_RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        valid_o = 1'b0;
        instr_o = '0;
        byp_vld = 1'b0;
`ifdef CELLRV32_VQ_BYPASS_EN
        // An empty queue is always in RUN, but keep the check explicit.
        byp_vld = empty && (state_q == VQ_RUN) && valid_i && !instr_i.reconfigure;
`else
        byp_vld = 1'b0;
`endif
        unique case (state_q)
            VQ_RUN:     valid_o = !empty && !head.reconfigure;
            VQ_DRAIN:   valid_o = 1'b0;
            VQ_RELEASE: valid_o = !empty;
            default:    valid_o = 1'b0;
        endcase
        if (!empty) begin
            instr_o = head;
        end else if (byp_vld) begin
            valid_o = 1'b1;
            instr_o = instr_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_adv) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_adv);
        end
    end

    assign ready_o   = !full;
    assign count_o   = count_q;
    assign is_idle_o = empty && (state_q == VQ_RUN);

    // The remapper must only consume a presented head.
    pop_protocol: assert property (@(posedge clk_i) disable iff (!rstn_i) pop_i |-> valid_o);

endmodule

// File: tb/tb_cellrv32_cpu_cp_vector_queue.sv
module tb_cellrv32_cpu_cp_vector_queue;
    import cellrv32_package::*;

    localparam int DEPTH = 4;
`ifdef CELLRV32_VQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       valid_i, ready_o, valid_o, pop_i, backend_idle_i, flush_i, is_idle_o;
    to_vector   instr_i, instr_o;
    logic [2:0] count_o;

    cellrv32_cpu_cp_vector_queue #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .valid_i        (valid_i),
        .instr_i        (instr_i),
        .ready_o        (ready_o),
        .valid_o        (valid_o),
        .instr_o        (instr_o),
        .pop_i          (pop_i),
        .backend_idle_i (backend_idle_i),
        .flush_i        (flush_i),
        .count_o        (count_o),
        .is_idle_o      (is_idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: ordered list of entries plus barrier bookkeeping.
    to_vector mq[$];
    int       m_age;   // cycles the current head has been at the head
    bit       m_rel;   // current reconfigure head has been released

    // Outputs sampled in the most recent step
    logic       s_valid, s_ready, s_idle;
    logic [4:0] s_dst;
    logic [2:0] s_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic to_vector mk(input logic [4:0] dst, input logic rc);
        to_vector t;
        t.opcode      = 7'($urandom);
        t.funct3      = 3'($urandom);
        t.dst         = dst;
        t.src1        = 5'($urandom);
        t.src2        = 5'($urandom);
        t.vm          = 1'($urandom);
        t.reconfigure = rc;
        return t;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_age = 0;
        m_rel = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, clock, update the model.
    task automatic step(input bit vi, input to_vector ins, input bit pop_req, input bit idle, input bit fl);
        bit pop, byp, ev, er, eidle, had_head, btake, popped, pushed;
        int ec;
        to_vector ei;
        @(negedge clk_i);
        valid_i = vi; instr_i = ins; backend_idle_i = idle; flush_i = fl; pop_i = 1'b0;
        #1;
        pop = pop_req && valid_o;
        pop_i = pop;
        #1;
        byp   = BYP && (mq.size() == 0) && vi && !ins.reconfigure;
        ev    = (mq.size() > 0) ? (!mq[0].reconfigure || m_rel) : byp;
        er    = (mq.size() != DEPTH);
        ec    = mq.size();
        eidle = (mq.size() == 0);
        ei    = (mq.size() > 0) ? mq[0] : (byp ? ins : '0);
        s_valid = valid_o; s_ready = ready_o; s_idle = is_idle_o;
        s_dst = instr_o.dst; s_count = count_o;
        chk("mdl_valid", 32'(valid_o), 32'(ev));
        chk("mdl_ready", 32'(ready_o), 32'(er));
        chk("mdl_count", 32'(count_o), 32'(ec));
        chk("mdl_idle",  32'(is_idle_o), 32'(eidle));
        chk("mdl_instr", 32'(instr_o), 32'(ei));
        @(posedge clk_i);
        if (fl) begin
            model_clear();
        end else begin
            had_head = (mq.size() > 0);
            btake  = byp && pop;
            popped = pop && ev && !btake;
            pushed = vi && er && !btake;
            if (pushed) mq.push_back(ins);
            if (popped) void'(mq.pop_front());
            if (popped || (!had_head && mq.size() > 0)) begin
                m_age = 0;
                m_rel = 1'b0;
            end else if (mq.size() > 0 && mq[0].reconfigure && !m_rel) begin
                // The head must first be seen for a cycle, then idle releases it.
                if (m_age >= 1 && idle) m_rel = 1'b1;
                m_age++;
            end
        end
    endtask

    typedef struct {
        bit         vi;
        logic [4:0] dst;
        bit         pop;
        bit         ev;
        bit         er;
        int         ec;
        logic [4:0] edst;
        bit         eidle;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; valid_i = 1'b0; instr_i = '0; pop_i = 1'b0;
        backend_idle_i = 1'b0; flush_i = 1'b0;
        model_clear();
        #12;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_idle",  32'(is_idle_o), 1);
        chk("rst_instr", 32'(instr_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Fill and drain, including push+pop while full (dst 6 refused).
        tbl[0] = '{1, 5'd1, 0, BYP, 1, 0, (BYP ? 5'd1 : 5'd0), 1};
        tbl[1] = '{1, 5'd2, 0, 1, 1, 1, 5'd1, 0};
        tbl[2] = '{1, 5'd3, 0, 1, 1, 2, 5'd1, 0};
        tbl[3] = '{1, 5'd4, 0, 1, 1, 3, 5'd1, 0};
        tbl[4] = '{1, 5'd5, 0, 1, 0, 4, 5'd1, 0};
        tbl[5] = '{1, 5'd6, 1, 1, 0, 4, 5'd1, 0};
        tbl[6] = '{0, 5'd0, 1, 1, 1, 3, 5'd2, 0};
        tbl[7] = '{0, 5'd0, 1, 1, 1, 2, 5'd3, 0};
        tbl[8] = '{0, 5'd0, 1, 1, 1, 1, 5'd4, 0};
        tbl[9] = '{0, 5'd0, 0, 0, 1, 0, 5'd0, 1};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].vi, mk(tbl[i].dst, 1'b0), tbl[i].pop, 1'b1, 1'b0);
            chk("tbl_valid", 32'(s_valid), 32'(tbl[i].ev));
            chk("tbl_ready", 32'(s_ready), 32'(tbl[i].er));
            chk("tbl_count", 32'(s_count), 32'(tbl[i].ec));
            chk("tbl_dst",   32'(s_dst),   32'(tbl[i].edst));
            chk("tbl_idle",  32'(s_idle),  32'(tbl[i].eidle));
        end

        // Wrap-around: push 3, pop 2, push 3, pop 4.
        for (int i = 0; i < 3; i++) step(1'b1, mk(5'(11 + i), 1'b0), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b0);
            chk("wrap_pop_a", 32'(s_dst), 32'(11 + i));
        end
        for (int i = 0; i < 3; i++) step(1'b1, mk(5'(14 + i), 1'b0), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b0);
            chk("wrap_pop_b", 32'(s_dst), 32'(13 + i));
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("wrap_count_end", 32'(s_count), 0);

        // Reconfigure barrier: [vadd, vsetvl, vsub] with backend busy.
        step(1'b1, mk(5'd1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(5'd2, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(5'd3, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("bar_vadd_valid", 32'(s_valid), 1);
        chk("bar_vadd_dst", 32'(s_dst), 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("bar_hold", 32'(s_valid), 0);
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("bar_idle_cycle", 32'(s_valid), 0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("bar_rel_valid", 32'(s_valid), 1);
        chk("bar_rel_dst", 32'(s_dst), 2);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("bar_vsub_valid", 32'(s_valid), 1);
        chk("bar_vsub_dst", 32'(s_dst), 3);

        // Flush while in DRAIN with a simultaneous push.
        step(1'b1, mk(5'd7, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(5'd8, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(5'd9, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_pre_count", 32'(s_count), 3);
        chk("flush_pre_idle", 32'(s_idle), 0);
        step(1'b1, mk(5'd10, 1'b0), 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_count", 32'(s_count), 0);
        chk("flush_valid", 32'(s_valid), 0);
        chk("flush_run_idle", 32'(s_idle), 1);

        // Push and pop on an empty queue in the same cycle.
        step(1'b1, mk(5'd6, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("byp_valid", 32'(s_valid), 32'(BYP));
        chk("byp_count", 32'(s_count), 0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("byp_next_valid", 32'(s_valid), 32'(!BYP));
        chk("byp_next_count", 32'(s_count), (BYP ? 0 : 1));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of DRAIN.
        step(1'b1, mk(5'd12, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        chk("arst_idle", 32'(is_idle_o), 1);
        chk("arst_count", 32'(count_o), 0);
        chk("arst_valid", 32'(valid_o), 0);
        model_clear();
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 9) < 7,
                 mk(5'($urandom), $urandom_range(0, 99) < 15),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
